// File: rtl/li_rr_arbiter.sv
// Round-robin arbiter folding NumInputs valid/bp channels into one registered output slot.
// Define LI_ARB_PKT_LOCK_EN to hold the grant on one input until its last beat (adds in_last/out_last).
module li_rr_arbiter #(
  parameter int Width     = 8,
  parameter int NumInputs = 4,
  parameter int IdxWidth  = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NumInputs*Width-1:0] in_data,
  input  logic [NumInputs-1:0]       in_valid,
  output logic [NumInputs-1:0]       in_bp,
`ifdef LI_ARB_PKT_LOCK_EN
  input  logic [NumInputs-1:0]       in_last,
  output logic                       out_last,
`endif
  output logic [Width-1:0]           out_data,
  output logic [IdxWidth-1:0]        out_idx,
  output logic                       out_valid,
  input  logic                       out_bp
);

  logic [Width-1:0]    data_p1;
  logic [IdxWidth-1:0] idx_p1;
  logic                vld_p1;
  logic [IdxWidth-1:0] ptr_q;

  logic                can_accept;
  logic                rr_any;
  logic [IdxWidth-1:0] rr_idx;
  logic                sel_any;
  logic [IdxWidth-1:0] sel_idx;
  logic [IdxWidth-1:0] nxt_ptr;
  logic [Width-1:0]    sel_data;
  logic [NumInputs-1:0] gnt;

  // Scan from the farthest candidate back to ptr so the closest valid input wins.
  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NumInputs) j = j - NumInputs;
      if (in_valid[j]) begin
        rr_any = 1'b1;
        rr_idx = IdxWidth'(j);
      end
    end
  end

`ifdef LI_ARB_PKT_LOCK_EN
  logic                lock_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                last_p1;
  logic                sel_last;

  assign sel_idx  = lock_q ? lock_idx_q : rr_idx;
  assign sel_any  = lock_q ? in_valid[lock_idx_q] : rr_any;
  assign sel_last = in_last[sel_idx];
  assign out_last = last_p1;
`else
  assign sel_idx = rr_idx;
  assign sel_any = rr_any;
`endif

  always_comb begin
    sel_data = '0;
    gnt      = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (sel_idx == IdxWidth'(i)) begin
        sel_data = in_data[i*Width +: Width];
        gnt[i]   = sel_any;
      end
    end
  end

  // Wrap at NumInputs so a non-power-of-two count never points past the last input.
  assign nxt_ptr    = (sel_idx == IdxWidth'(NumInputs - 1)) ? '0 : sel_idx + IdxWidth'(1);
  assign can_accept = ~vld_p1 | ~out_bp;
  assign in_bp      = ~({NumInputs{can_accept}} & gnt);

  // Stage p1: output slot capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_p1 <= '0;
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
      ptr_q   <= '0;
`ifdef LI_ARB_PKT_LOCK_EN
      last_p1    <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else if (can_accept) begin
      if (sel_any) begin
        data_p1 <= sel_data;
        idx_p1  <= sel_idx;
        vld_p1  <= 1'b1;
`ifdef LI_ARB_PKT_LOCK_EN
        last_p1    <= sel_last;
        lock_q     <= ~sel_last;
        lock_idx_q <= sel_idx;
        if (sel_last) ptr_q <= nxt_ptr;
`else
        ptr_q   <= nxt_ptr;
`endif
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_idx   = idx_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_li_rr_arbiter.sv
// Bench for li_rr_arbiter: directed and random steps checked against a behavioural round-robin model.
module tb_li_rr_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_bp;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_bp;
`ifdef LI_ARB_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic [2:0]  in_last3 = 3'b111;
  logic        out_last3;
`endif

  logic [23:0] in_data3  = 24'h222120;
  logic [2:0]  in_valid3 = 3'b111;
  logic [2:0]  in_bp3;
  logic [7:0]  out_data3;
  logic [1:0]  out_idx3;
  logic        out_valid3;
  logic        out_bp3 = 1'b0;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit         m_vld;
  logic [7:0] m_data;
  int         m_idx;
  int         m_ptr;

  always #5 clk = ~clk;

  li_rr_arbiter #(.Width(8), .NumInputs(4), .IdxWidth(2)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_bp(in_bp),
`ifdef LI_ARB_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_bp(out_bp)
  );

  li_rr_arbiter #(.Width(8), .NumInputs(3), .IdxWidth(2)) dut3 (
    .clk(clk), .resetn(resetn), .in_data(in_data3), .in_valid(in_valid3), .in_bp(in_bp3),
`ifdef LI_ARB_PKT_LOCK_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_data(out_data3), .out_idx(out_idx3), .out_valid(out_valid3), .out_bp(out_bp3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = 8'h00; m_idx = 0; m_ptr = 0;
  endtask

  // One clock: check in_bp before the edge, advance the model, check the slot after it.
  task automatic step(input string tag);
    int g;
    bit can;
    logic [3:0] ebp;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    can = !m_vld || !out_bp;
    ebp = 4'b1111;
    if (can && g >= 0) ebp[g] = 1'b0;
    chk({tag, ".in_bp"}, 32'(in_bp), 32'(ebp));
    @(posedge clk);
    if (can) begin
      if (g >= 0) begin
        m_data = in_data[g*8 +: 8];
        m_idx  = g;
        m_vld  = 1;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_vld = 0;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".out_idx"}, 32'(out_idx), 32'(m_idx));
  endtask

`ifdef LI_ARB_PKT_LOCK_EN
  task automatic lk(input string tag, input logic [3:0] ebp, input logic [7:0] edata,
                    input logic [1:0] eidx, input logic elast);
    #1;
    chk({tag, ".in_bp"}, 32'(in_bp), 32'(ebp));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_data"}, 32'(out_data), 32'(edata));
    chk({tag, ".out_idx"}, 32'(out_idx), 32'(eidx));
    chk({tag, ".out_last"}, 32'(out_last), 32'(elast));
  endtask
`endif

  initial begin
    resetn   = 1'b0;
    in_data  = 32'h13121110;
    in_valid = 4'b0000;
    out_bp   = 1'b0;
`ifdef LI_ARB_PKT_LOCK_EN
    in_last  = 4'b1111;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_idx", 32'(out_idx), 32'd0);
    chk("rst.in_bp", 32'(in_bp), 32'hF);
    resetn = 1'b1;

    // idle main DUT while the 3-input instance streams 0,1,2,0,...
    for (int k = 0; k < 7; k++) begin
      step("idle");
      chk("n3.out_valid", 32'(out_valid3), 32'd1);
      chk("n3.out_idx", 32'(out_idx3), 32'(k % 3));
      chk("n3.out_data", 32'(out_data3), 32'(8'h20 + (k % 3)));
    end

    // all inputs valid: 0,1,2,3,0,... at one token per cycle
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step("fair");
      chk("fair.seq_idx", 32'(out_idx), 32'(k % 4));
    end

    // reset mid-stream takes effect without a clock edge
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_data", 32'(out_data), 32'd0);
    chk("mid_rst.out_idx", 32'(out_idx), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) step("post_rst");

    // single requester on input 2
    in_valid = 4'b0100;
    in_data  = 32'h00A50000;
    #1;
    chk("only2.in_bp_direct", 32'(in_bp), 32'b1011);
    step("only2");
    chk("only2.idx_direct", 32'(out_idx), 32'd2);
    in_valid = 4'b1111;
    in_data  = 32'h13121110;
    step("after2");
    chk("after2.idx_direct", 32'(out_idx), 32'd3);

    // held backpressure with full slot, then release
    out_bp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("bp");
      chk("bp.data_stable", 32'(out_data), 32'h13);
    end
    out_bp = 1'b0;
    step("bp_release");
    chk("bp_release.idx_direct", 32'(out_idx), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      in_data  = $urandom;
      in_valid = 4'($urandom_range(0, 15));
      out_bp   = ($urandom_range(0, 3) == 0);
      step("rand");
    end

`ifdef LI_ARB_PKT_LOCK_EN
    out_bp   = 1'b0;
    in_valid = 4'b0000;
    resetn   = 1'b0;
    @(negedge clk);
    resetn   = 1'b1;
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    in_data  = 32'h00000040;
    lk("pkt.pre", 4'b1110, 8'h40, 2'd0, 1'b1);
    in_valid = 4'b0011;
    in_data  = 32'h00003140;
    lk("pkt.b1", 4'b1101, 8'h31, 2'd1, 1'b0);
    in_data  = 32'h00003240;
    lk("pkt.b2", 4'b1101, 8'h32, 2'd1, 1'b0);
    in_data  = 32'h00003340;
    in_last  = 4'b0011;
    lk("pkt.b3", 4'b1101, 8'h33, 2'd1, 1'b1);
    lk("pkt.next", 4'b1110, 8'h40, 2'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
